if_fetch: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32I pipeline; owns the PC and drives IF/ID inputs for decode.

---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/if_fetch_predecode.sv | 27 ++
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg - shared types for the RV32I fetch stage: FSM state encoding,
// the canonical NOP word and the base opcode map used by predecode.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        SQUASH
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

endpackage

// File: rtl/if_fetch_predecode.sv
// if_predecode - combinational B/J immediate extraction and BTFN decision on a
// freshly fetched word. Only instantiated when IF_STATIC_PREDICT_EN is defined.
module if_predecode
    import if_fetch_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0] instr,
    input  logic [width-1:0] pc,
    output logic             pred_taken,
    output logic [width-1:0] target
);
    logic             is_br;
    logic             is_jal;
    logic [width-1:0] b_imm;
    logic [width-1:0] j_imm;

    assign is_br  = (instr[6:0] == op_br);
    assign is_jal = (instr[6:0] == op_jal);
    assign b_imm  = {{(width-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm  = {{(width-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Backward branches and all JALs are predicted taken.
    assign pred_taken = is_jal | (is_br & b_imm[width-1]);
    assign target     = pc + (is_jal ? j_imm : b_imm);

endmodule

// File: rtl/if_fetch.sv
// if_fetch - IF stage of the 5-stage RV32I pipeline. Owns the PC, issues one
// imem read at a time, drops responses made stale by a redirect and parks a
// fetched word while decode is stalled.
// Optional macro IF_STATIC_PREDICT_EN: BTFN static prediction on fetched words.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned      width    = 32,
    parameter logic [width-1:0] RESET_PC = 32'h6000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_stall_i,
    input  logic             IF_redirect_i,
    input  logic [width-1:0] IF_target_i,
    output logic             imem_read_o,
    output logic [width-1:0] imem_address_o,
    input  logic [width-1:0] imem_rdata_i,
    input  logic             imem_resp_i,
    output logic [width-1:0] IFID_instr_o,
    output logic [width-1:0] IFID_pc_out_o,
    output logic             IFID_valid_o,
    output logic             IFID_pred_taken_o
);
    localparam logic [width-1:0] NOP = width'(NOP_INSTR);

    typedef struct packed {
        logic [width-1:0] instr;
        logic [width-1:0] pc;
        logic             pred;
    } fetch_word_t;

    fetch_state_e     state;
    logic [width-1:0] pc_q;
    logic [width-1:0] req_addr_q;
    fetch_word_t      hold_q;
    logic [width-1:0] next_pc;
    logic             pred_taken;

`ifdef IF_STATIC_PREDICT_EN
    logic [width-1:0] pred_target;

    if_predecode #(.width(width)) u_predecode (
        .instr      (imem_rdata_i),
        .pc         (req_addr_q),
        .pred_taken (pred_taken),
        .target     (pred_target)
    );

    assign next_pc = pred_taken ? pred_target : req_addr_q + width'(4);
`else
    assign pred_taken = 1'b0;
    assign next_pc    = req_addr_q + width'(4);
`endif

    // The request address is only ever changed on a response or leaving HOLD,
    // so it stays stable for the whole life of an outstanding read.
    assign imem_address_o = req_addr_q;

    // Fetch FSM plus IF/ID output registers; per-state deliveries override the
    // redirect/stall/bubble default applied first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= FETCH;
            pc_q              <= RESET_PC;
            req_addr_q        <= RESET_PC;
            imem_read_o       <= 1'b0;
            hold_q            <= '0;
            IFID_instr_o      <= NOP;
            IFID_pc_out_o     <= '0;
            IFID_valid_o      <= 1'b0;
            IFID_pred_taken_o <= 1'b0;
        end else begin
            if (IF_redirect_i || !IF_stall_i) begin
                IFID_instr_o      <= NOP;
                IFID_valid_o      <= 1'b0;
                IFID_pred_taken_o <= 1'b0;
            end
            case (state)
                FETCH: begin
                    imem_read_o <= 1'b1;
                    if (imem_resp_i && IF_redirect_i) begin
                        pc_q       <= IF_target_i;
                        req_addr_q <= IF_target_i;
                    end else if (imem_resp_i && !IF_stall_i) begin
                        IFID_instr_o      <= imem_rdata_i;
                        IFID_pc_out_o     <= req_addr_q;
                        IFID_valid_o      <= 1'b1;
                        IFID_pred_taken_o <= pred_taken;
                        pc_q              <= next_pc;
                        req_addr_q        <= next_pc;
                    end else if (imem_resp_i) begin
                        hold_q.instr <= imem_rdata_i;
                        hold_q.pc    <= req_addr_q;
                        hold_q.pred  <= pred_taken;
                        pc_q         <= next_pc;
                        imem_read_o  <= 1'b0;
                        state        <= HOLD;
                    end else if (IF_redirect_i) begin
                        // Read still in flight: remember the target, drain the old response.
                        pc_q  <= IF_target_i;
                        state <= SQUASH;
                    end
                end
                HOLD: begin
                    if (IF_redirect_i) begin
                        pc_q        <= IF_target_i;
                        req_addr_q  <= IF_target_i;
                        imem_read_o <= 1'b1;
                        state       <= FETCH;
                    end else if (!IF_stall_i) begin
                        IFID_instr_o      <= hold_q.instr;
                        IFID_pc_out_o     <= hold_q.pc;
                        IFID_valid_o      <= 1'b1;
                        IFID_pred_taken_o <= hold_q.pred;
                        req_addr_q        <= pc_q;
                        imem_read_o       <= 1'b1;
                        state             <= FETCH;
                    end
                end
                SQUASH: begin
                    imem_read_o <= 1'b1;
                    if (IF_redirect_i) pc_q <= IF_target_i;
                    if (imem_resp_i) begin
                        req_addr_q <= IF_redirect_i ? IF_target_i : pc_q;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch - randomized scoreboard bench for if_fetch. A program-order model
// predicts the sequence of (pc, instr, pred) words decode must see; an imem
// model answers reads with random latency; a monitor checks every IF/ID edge.
module tb_if_fetch;
    localparam logic [31:0] RST_PC = 32'h6000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        resp = 1'b0;
    logic [31:0] rdata = '0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        ifid_pred;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .IF_stall_i        (stall),
        .IF_redirect_i     (redirect),
        .IF_target_i       (target),
        .imem_read_o       (imem_read),
        .imem_address_o    (imem_address),
        .imem_rdata_i      (rdata),
        .imem_resp_i       (resp),
        .IFID_instr_o      (ifid_instr),
        .IFID_pc_out_o     (ifid_pc),
        .IFID_valid_o      (ifid_valid),
        .IFID_pred_taken_o (ifid_pred)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, req);
        end
    endtask

    // Program image: a backward BEQ (-8), a forward BEQ (+8) and a JAL (+16)
    // in every 64-byte block, everything else an ALU-immediate word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[5:2])
            4'd3:    return 32'hFE00_0CE3;
            4'd9:    return 32'h0000_0463;
            4'd13:   return 32'h0100_006F;
            default: return {a[24:0] ^ 25'h00A_CE1, 7'h13};
        endcase
    endfunction

    // Returns 1 when the word is predicted taken; off is the branch offset.
    function automatic bit predicts(input logic [31:0] w, output int off);
        off = 4;
`ifdef IF_STATIC_PREDICT_EN
        if (w[6:0] == 7'h6F) begin
            off = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                + int'(w[30:21]) * 2;
            return 1'b1;
        end
        if (w[6:0] == 7'h63) begin
            off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                + int'(w[11:8]) * 2;
            if (off < 0) return 1'b1;
            off = 4;
        end
`endif
        return 1'b0;
    endfunction

    task automatic refill();
        exp_t e;
        int   off;
        while (exp_q.size() < 4) begin
            e.pc    = model_pc;
            e.instr = mem_word(model_pc);
            e.pred  = predicts(e.instr, off);
            exp_q.push_back(e);
            model_pc = model_pc + 32'(off);
        end
    endtask

    // Monitor: at posedge+1, judge the edge just taken using the inputs that
    // were applied during the cycle before it.
    initial begin
        logic [31:0] s_instr = NOP;
        logic [31:0] s_pc = '0;
        logic        s_valid = 1'b0;
        logic        s_pred = 1'b0;
        exp_t        e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("rst_read", 64'(imem_read), 64'(0));
                chk("rst_valid", 64'(ifid_valid), 64'(0));
                chk("rst_instr", 64'(ifid_instr), 64'(NOP));
                chk("rst_pc", 64'(ifid_pc), 64'(0));
                chk("rst_pred", 64'(ifid_pred), 64'(0));
            end else if (redirect) begin
                chk("redir_valid", 64'(ifid_valid), 64'(0));
                chk("redir_instr", 64'(ifid_instr), 64'(NOP));
            end else if (stall) begin
                chk("stall_hold", {ifid_instr, ifid_pc[29:0], ifid_valid, ifid_pred},
                    {s_instr, s_pc[29:0], s_valid, s_pred});
            end else if (ifid_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(ifid_pc), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("word_pc", 64'(ifid_pc), 64'(e.pc));
                    chk("word_instr", 64'(ifid_instr), 64'(e.instr));
                    chk("word_pred", 64'(ifid_pred), 64'(e.pred));
                    delivered++;
                    refill();
                end
            end else begin
                chk("bubble_instr", 64'(ifid_instr), 64'(NOP));
            end
            s_instr = ifid_instr;
            s_pc    = ifid_pc;
            s_valid = ifid_valid;
            s_pred  = ifid_pred;
        end
    end

    // Stimulus + imem model: at posedge+2 drive this cycle's inputs.
    initial begin
        bit          busy = 1'b0;
        int          cnt = 0;
        logic [31:0] req_a = '0;
        model_pc = RST_PC;
        refill();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #2;
            if (cyc == 1500) begin
                // Reset in the middle of traffic; any read in flight is abandoned.
                rst = 1'b0;
                stall = 1'b0;
                redirect = 1'b0;
                resp = 1'b0;
                busy = 1'b0;
                exp_q.delete();
                model_pc = RST_PC;
                refill();
                repeat (3) @(posedge clk);
                #2 rst = 1'b1;
            end
            resp = 1'b0;
            if (busy) begin
                chk("req_held", {31'b0, imem_read, imem_address}, {31'b0, 1'b1, req_a});
            end else if (imem_read) begin
                busy  = 1'b1;
                req_a = imem_address;
                cnt   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                chk("addr_align", 64'(imem_address[1:0]), 64'(0));
            end
            if (busy) begin
                if (cnt == 0) begin
                    resp  = 1'b1;
                    rdata = mem_word(req_a);
                    busy  = 1'b0;
                end else begin
                    cnt--;
                end
            end
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            if (redirect) begin
                case ($urandom_range(0, 2))
                    0:       target = 32'h6000_0100;
                    1:       target = 32'hFFFF_FFF0;
                    default: target = $urandom() & 32'hFFFF_FFFC;
                endcase
                exp_q.delete();
                model_pc = target;
                refill();
            end
        end
        @(posedge clk);
        #2;
        stall = 1'b0;
        redirect = 1'b0;
        resp = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("enough_deliveries", 64'(delivered > 300), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
